// File: rtl/ctrl_resolve_pkg.sv
// Shared definitions for the branch resolve unit: execution flag bit positions,
// recovery FSM states and the predictor-update entry layout.
package ctrl_resolve_pkg;

    localparam int FLAG_MISPRED = 0;
    localparam int FLAG_COND    = 2;
    localparam int FLAG_CTRL    = 5;

    localparam int PC_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        RECOVER
    } resolve_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
        logic                dir;
        logic                is_cond;
    } upd_entry_t;

endpackage

// File: rtl/resolve_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head, so the head
// entry reaches the output straight from a flop with no bypass from the push side.
module resolve_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 66
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_next;
    logic [WIDTH-1:0] head_next;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign count     = wr_ptr - rd_ptr;
    assign not_empty = !empty;

    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_pop};

    // A push lands in the head slot only when the FIFO is (or is becoming) empty.
    always_comb begin
        head_next = mem[rd_ptr_next[AW-1:0]];
        if (do_push && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_data <= '0;
        end else begin
            wr_ptr    <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr    <= rd_ptr_next;
            head_data <= head_next;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Consumes resolved control-transfer results, queues predictor updates in order
// and raises a one-cycle fetch redirect followed by a fixed recovery window.
module branch_resolve_unit
    import ctrl_resolve_pkg::*;
#(
    parameter int SIZE_PC         = 32,
    parameter int DEPTH           = 8,
    parameter int SIZE_CTI_ID     = 4,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   exeValid_i,
    input  logic [SIZE_PC-1:0]     exePC_i,
    input  logic [SIZE_PC-1:0]     exeNextPC_i,
    input  logic                   exeDirection_i,
    input  logic [7:0]             exeFlags_i,
    input  logic [SIZE_CTI_ID-1:0] exeCtiId_i,
    output logic                   exeReady_o,
    output logic                   updValid_o,
    input  logic                   updReady_i,
    output logic [SIZE_PC-1:0]     updPC_o,
    output logic [SIZE_PC-1:0]     updTarget_o,
    output logic                   updDir_o,
    output logic                   updIsCond_o,
    output logic                   redirectValid_o,
    output logic [SIZE_PC-1:0]     redirectPC_o,
    output logic [SIZE_CTI_ID-1:0] flushCtiId_o,
    output logic                   recoverBusy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(RECOVERY_CYCLES + 1);

    typedef struct packed {
        logic [SIZE_PC-1:0] pc;
        logic [SIZE_PC-1:0] target;
        logic               dir;
        logic               is_cond;
    } entry_t;

    resolve_state_t state;
    resolve_state_t next_state;
    logic [RW-1:0]  rec_cnt;
    logic           accept;
    logic           mispredict;
    entry_t         push_entry;
    entry_t         head_entry;
    logic           unused_flags;

    assign unused_flags = ^{exeFlags_i[7:6], exeFlags_i[4:3], exeFlags_i[1]};

    assign exeReady_o = (state == IDLE) && (count_o < CW'(DEPTH));
    assign accept     = exeValid_i && exeReady_o && exeFlags_i[FLAG_CTRL];
    assign mispredict = accept && exeFlags_i[FLAG_MISPRED];

    // Mispredicted instructions still train the predictor with their corrected outcome.
    assign push_entry.pc      = exePC_i;
    assign push_entry.target  = exeNextPC_i;
    assign push_entry.dir     = exeDirection_i;
    assign push_entry.is_cond = exeFlags_i[FLAG_COND];

    resolve_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (updValid_o && updReady_i),
        .head_data (head_entry),
        .not_empty (updValid_o),
        .count     (count_o)
    );

    assign updPC_o     = head_entry.pc;
    assign updTarget_o = head_entry.target;
    assign updDir_o    = head_entry.dir;
    assign updIsCond_o = head_entry.is_cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_cnt <= '0;
        end else if (state == REDIRECT) begin
            rec_cnt <= RW'(RECOVERY_CYCLES);
        end else if (state == RECOVER) begin
            rec_cnt <= rec_cnt - RW'(1);
        end
    end

    // Redirect target and flush tag stay visible until the next mispredict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirectPC_o <= '0;
            flushCtiId_o <= '0;
        end else if (mispredict) begin
            redirectPC_o <= exeNextPC_i;
            flushCtiId_o <= exeCtiId_i;
        end
    end

    always_comb begin
        next_state      = state;
        redirectValid_o = 1'b0;
        recoverBusy_o   = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    next_state = REDIRECT;
                end
            end
            REDIRECT: begin
                redirectValid_o = 1'b1;
                recoverBusy_o   = 1'b1;
                next_state      = RECOVER;
            end
            RECOVER: begin
                recoverBusy_o = 1'b1;
                if (rec_cnt == RW'(1)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random
// traffic, compared every cycle against a queue-based reference model.
module tb_branch_resolve_unit;
    import ctrl_resolve_pkg::*;

    localparam int SIZE_PC         = 32;
    localparam int DEPTH           = 8;
    localparam int SIZE_CTI_ID     = 4;
    localparam int RECOVERY_CYCLES = 2;
    localparam int CW              = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   exeValid_i;
    logic [SIZE_PC-1:0]     exePC_i;
    logic [SIZE_PC-1:0]     exeNextPC_i;
    logic                   exeDirection_i;
    logic [7:0]             exeFlags_i;
    logic [SIZE_CTI_ID-1:0] exeCtiId_i;
    logic                   exeReady_o;
    logic                   updValid_o;
    logic                   updReady_i;
    logic [SIZE_PC-1:0]     updPC_o;
    logic [SIZE_PC-1:0]     updTarget_o;
    logic                   updDir_o;
    logic                   updIsCond_o;
    logic                   redirectValid_o;
    logic [SIZE_PC-1:0]     redirectPC_o;
    logic [SIZE_CTI_ID-1:0] flushCtiId_o;
    logic                   recoverBusy_o;
    logic [CW-1:0]          count_o;

    upd_entry_t             model_q[$];
    int                     busy_left;
    logic [SIZE_PC-1:0]     model_rpc;
    logic [SIZE_CTI_ID-1:0] model_fid;
    int                     checks = 0;
    int                     errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .SIZE_PC         (SIZE_PC),
        .DEPTH           (DEPTH),
        .SIZE_CTI_ID     (SIZE_CTI_ID),
        .RECOVERY_CYCLES (RECOVERY_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .exeValid_i      (exeValid_i),
        .exePC_i         (exePC_i),
        .exeNextPC_i     (exeNextPC_i),
        .exeDirection_i  (exeDirection_i),
        .exeFlags_i      (exeFlags_i),
        .exeCtiId_i      (exeCtiId_i),
        .exeReady_o      (exeReady_o),
        .updValid_o      (updValid_o),
        .updReady_i      (updReady_i),
        .updPC_o         (updPC_o),
        .updTarget_o     (updTarget_o),
        .updDir_o        (updDir_o),
        .updIsCond_o     (updIsCond_o),
        .redirectValid_o (redirectValid_o),
        .redirectPC_o    (redirectPC_o),
        .flushCtiId_o    (flushCtiId_o),
        .recoverBusy_o   (recoverBusy_o),
        .count_o         (count_o)
    );

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        busy_left = 0;
        model_rpc = '0;
        model_fid = '0;
    endtask

    // Busy window spans the redirect cycle plus the recovery cycles; the pulse is its first cycle.
    task automatic checkOutput();
        int n;
        n = model_q.size();
        checkValue("exe_ready", 64'(exeReady_o), 64'((busy_left == 0) && (n < DEPTH)));
        checkValue("upd_valid", 64'(updValid_o), 64'(n != 0));
        if (n != 0) begin
            checkValue("upd_pc", 64'(updPC_o), 64'(model_q[0].pc));
            checkValue("upd_target", 64'(updTarget_o), 64'(model_q[0].target));
            checkValue("upd_dir", 64'(updDir_o), 64'(model_q[0].dir));
            checkValue("upd_is_cond", 64'(updIsCond_o), 64'(model_q[0].is_cond));
        end
        checkValue("redirect_valid", 64'(redirectValid_o), 64'(busy_left == RECOVERY_CYCLES + 1));
        checkValue("recover_busy", 64'(recoverBusy_o), 64'(busy_left != 0));
        checkValue("redirect_pc", 64'(redirectPC_o), 64'(model_rpc));
        checkValue("flush_cti_id", 64'(flushCtiId_o), 64'(model_fid));
        checkValue("count", 64'(count_o), 64'(n));
    endtask

    task automatic applyStimulus(input logic valid, input logic [SIZE_PC-1:0] pc,
                                 input logic [SIZE_PC-1:0] npc, input logic dir,
                                 input logic [7:0] flags, input logic [SIZE_CTI_ID-1:0] id,
                                 input logic rdy);
        bit acc;
        bit pop;
        upd_entry_t e;
        exeValid_i     = valid;
        exePC_i        = pc;
        exeNextPC_i    = npc;
        exeDirection_i = dir;
        exeFlags_i     = flags;
        exeCtiId_i     = id;
        updReady_i     = rdy;
        #1;
        checkOutput();
        acc = valid && (busy_left == 0) && (model_q.size() < DEPTH) && flags[5];
        pop = (model_q.size() != 0) && rdy;
        if (pop) void'(model_q.pop_front());
        if (busy_left > 0) busy_left--;
        if (acc) begin
            e.pc      = pc;
            e.target  = npc;
            e.dir     = dir;
            e.is_cond = flags[2];
            model_q.push_back(e);
            if (flags[0]) begin
                busy_left = RECOVERY_CYCLES + 1;
                model_rpc = npc;
                model_fid = id;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep(input logic rdy);
        applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, '0, rdy);
    endtask

    initial begin
        reset          = 1'b1;
        exeValid_i     = 1'b0;
        exePC_i        = '0;
        exeNextPC_i    = '0;
        exeDirection_i = 1'b0;
        exeFlags_i     = '0;
        exeCtiId_i     = '0;
        updReady_i     = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;

        $display("[TB] in-order correctly predicted updates");
        applyStimulus(1'b1, 32'h100, 32'h120, 1'b1, 8'h24, 4'd1, 1'b1);
        applyStimulus(1'b1, 32'h200, 32'h1000, 1'b1, 8'h20, 4'd2, 1'b1);
        applyStimulus(1'b1, 32'h300, 32'h304, 1'b0, 8'h24, 4'd3, 1'b1);
        idleStep(1'b1);
        idleStep(1'b1);

        $display("[TB] mispredict, redirect and dropped wrong-path result");
        applyStimulus(1'b1, 32'h400, 32'h408, 1'b1, 8'h25, 4'd5, 1'b1);
        idleStep(1'b1);
        applyStimulus(1'b1, 32'h800, 32'h900, 1'b1, 8'h25, 4'd9, 1'b1);
        idleStep(1'b1);
        idleStep(1'b1);
        checkValue("redirect_hold", 64'(redirectPC_o), 64'h408);
        checkValue("flush_hold", 64'(flushCtiId_o), 64'd5);

        $display("[TB] full FIFO and wrap");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(i * 4), 32'h700 + 32'(i * 8), i[0], 8'h24, 4'(i), 1'b0);
        end
        checkValue("full_count", 64'(count_o), 64'(DEPTH));
        checkValue("full_ready", 64'(exeReady_o), 64'd0);
        applyStimulus(1'b1, 32'h5f0, 32'h5f4, 1'b0, 8'h24, 4'd7, 1'b0);
        idleStep(1'b1);
        applyStimulus(1'b1, 32'h600, 32'h604, 1'b1, 8'h24, 4'd8, 1'b1);
        checkValue("count_steady", 64'(count_o), 64'(DEPTH - 1));
        repeat (DEPTH + 1) idleStep(1'b1);

        $display("[TB] non-control result ignored");
        applyStimulus(1'b1, 32'ha00, 32'ha40, 1'b1, 8'h05, 4'd3, 1'b1);
        idleStep(1'b1);

        $display("[TB] reset during recovery");
        applyStimulus(1'b1, 32'hb00, 32'hb04, 1'b0, 8'h24, 4'd1, 1'b0);
        applyStimulus(1'b1, 32'hb10, 32'hb14, 1'b0, 8'h20, 4'd2, 1'b0);
        applyStimulus(1'b1, 32'hb20, 32'hb24, 1'b0, 8'h24, 4'd3, 1'b0);
        applyStimulus(1'b1, 32'hb30, 32'hc00, 1'b1, 8'h25, 4'd4, 1'b0);
        idleStep(1'b0);
        reset = 1'b1;
        #1;
        modelReset();
        checkValue("rst_busy", 64'(recoverBusy_o), 64'd0);
        checkValue("rst_count", 64'(count_o), 64'd0);
        checkValue("rst_upd_valid", 64'(updValid_o), 64'd0);
        checkValue("rst_ready", 64'(exeReady_o), 64'd1);
        checkValue("rst_redirect", 64'(redirectValid_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleStep(1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [7:0] f;
            f    = 8'($urandom);
            f[5] = ($urandom_range(0, 7) != 0);
            f[0] = ($urandom_range(0, 7) == 0);
            applyStimulus(1'($urandom), $urandom, $urandom, 1'($urandom), f,
                          SIZE_CTI_ID'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
